// File: rtl/lfsr_bank.sv
// lfsr_bank: NUM_CH independent Galois LFSR generators with warm-up and runtime reseed.
// Define LFSR_LEAP_EN to make one draw-step OUT_W unrolled single steps (leap-forward).
module lfsr_bank #(
    parameter int unsigned          WIDTH  = 16,
    parameter int unsigned          OUT_W  = 8,
    parameter int unsigned          NUM_CH = 4,
    parameter logic [WIDTH-1:0]     TAPS   = 16'hB400,
    parameter int unsigned          WARMUP = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          seed,
    input  logic                      load,
    input  logic [NUM_CH-1:0]         next,
    output logic                      ready,
    output logic [NUM_CH*OUT_W-1:0]   rnd,
    output logic [NUM_CH-1:0]         rnd_vld
);

    typedef enum logic {WARM, READY} state_e;

    state_e                     state_q, state_d;
    logic [31:0]                cnt_q, cnt_d;
    logic                       ready_q, ready_d;
    logic [NUM_CH*OUT_W-1:0]    rnd_q, rnd_d;
    logic [NUM_CH-1:0]          vld_q, vld_d;
    logic [WIDTH-1:0]           lfsr_q [NUM_CH];
    logic [WIDTH-1:0]           lfsr_d [NUM_CH];
    logic [WIDTH-1:0]           seed_ch [NUM_CH];

    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
        step1 = (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    function automatic logic [WIDTH-1:0] draw_step(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s;
`ifdef LFSR_LEAP_EN
        for (int unsigned k = 0; k < OUT_W; k++) begin
            r = step1(r);
        end
`else
        r = step1(r);
`endif
        draw_step = r;
    endfunction

    // An all-zero state would lock the LFSR, so it is replaced by all-ones.
    function automatic logic [WIDTH-1:0] chan_seed(input logic [WIDTH-1:0] s,
                                                    input int unsigned   ch);
        logic [WIDTH-1:0] v;
        v = s ^ WIDTH'(ch);
        if (v == '0) begin
            v = '1;
        end
        chan_seed = v;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            seed_ch[i] = chan_seed(seed, i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        rnd_d   = rnd_q;
        vld_d   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            lfsr_d[i] = lfsr_q[i];
        end

        if (load) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                lfsr_d[i] = seed_ch[i];
            end
            cnt_d   = 32'(WARMUP);
            state_d = WARM;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                WARM: begin
                    if (cnt_q == '0) begin
                        state_d = READY;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            lfsr_d[i] = draw_step(lfsr_q[i]);
                        end
                    end
                end
                READY: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (next[i]) begin
                            lfsr_d[i]                   = draw_step(lfsr_q[i]);
                            rnd_d[i*OUT_W +: OUT_W]     = lfsr_d[i][WIDTH-1 -: OUT_W];
                            vld_d[i]                    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = WARM;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WARM;
            cnt_q   <= 32'(WARMUP);
            ready_q <= 1'b0;
            rnd_q   <= '0;
            vld_q   <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                lfsr_q[i] <= seed_ch[i];
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rnd_q   <= rnd_d;
            vld_q   <= vld_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                lfsr_q[i] <= lfsr_d[i];
            end
        end
    end

    assign ready   = ready_q;
    assign rnd     = rnd_q;
    assign rnd_vld = vld_q;

endmodule

// File: tb/tb_lfsr_bank.sv
// Bench for lfsr_bank: two instances (WARMUP=0 and WARMUP=3) against a step-count model.
module tb_lfsr_bank;

    localparam logic [15:0] TAPS = 16'hB400;
`ifdef LFSR_LEAP_EN
    localparam int D = 8;
`else
    localparam int D = 1;
`endif
    localparam int WU [2] = '{0, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] seed = 16'hFFFF;
    logic [1:0]  next = 2'b00;

    logic        rdy_o [2];
    logic [15:0] rnd_o [2];
    logic [1:0]  vld_o [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_bank #(.WIDTH(16), .OUT_W(8), .NUM_CH(2), .TAPS(16'hB400), .WARMUP(0)) dut_w0 (
        .clk(clk), .rst(rst), .seed(seed), .load(load), .next(next),
        .ready(rdy_o[0]), .rnd(rnd_o[0]), .rnd_vld(vld_o[0])
    );

    lfsr_bank #(.WIDTH(16), .OUT_W(8), .NUM_CH(2), .TAPS(16'hB400), .WARMUP(3)) dut_w3 (
        .clk(clk), .rst(rst), .seed(seed), .load(load), .next(next),
        .ready(rdy_o[1]), .rnd(rnd_o[1]), .rnd_vld(vld_o[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_at(input logic [15:0] s0, input int n);
        logic [15:0] s;
        s = s0;
        for (int j = 0; j < n; j++) begin
            if (s[0]) s = (s >> 1) ^ TAPS;
            else      s = s >> 1;
        end
        return s;
    endfunction

    function automatic logic [15:0] seed_of(input logic [15:0] s, input int ch);
        logic [15:0] v;
        v = s ^ 16'(ch);
        if (v == 16'h0000) v = 16'hFFFF;
        return v;
    endfunction

    // Model: channel state = seed_i advanced D*(warm-up edges + draws) single steps.
    logic [15:0] m_seed [2];
    int          m_age [2];
    int          m_draws [2][2];
    logic [7:0]  m_rnd [2][2];
    logic [1:0]  m_vld [2];
    logic        m_rdy [2];
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        logic [15:0] st;
        for (int k = 0; k < 2; k++) begin
            if (rst || load) begin
                m_seed[k] = seed;
                m_age[k]  = 0;
                m_vld[k]  = 2'b00;
                m_rdy[k]  = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    m_draws[k][c] = 0;
                    if (rst) m_rnd[k][c] = 8'h00;
                end
            end else if (m_age[k] >= WU[k] + 1) begin
                for (int c = 0; c < 2; c++) begin
                    m_vld[k][c] = next[c];
                    if (next[c]) begin
                        m_draws[k][c]++;
                        st = lfsr_at(seed_of(m_seed[k], c), D * (WU[k] + m_draws[k][c]));
                        m_rnd[k][c] = st[15:8];
                    end
                end
            end else begin
                m_vld[k] = 2'b00;
                m_age[k]++;
                m_rdy[k] = (m_age[k] >= WU[k] + 1);
            end
        end
        if (rst) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ready[%0d]", k), 32'(rdy_o[k]), 32'(m_rdy[k]));
                chk($sformatf("rnd_vld[%0d]", k), 32'(vld_o[k]), 32'(m_vld[k]));
                chk($sformatf("rnd[%0d]", k), 32'(rnd_o[k]), 32'({m_rnd[k][1], m_rnd[k][0]}));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] pat [16];
        pat = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10,
                2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11};

        // Reset held two cycles
        repeat (2) cyc();
        chk("rst_ready", 32'(rdy_o[1]), 32'd0);
        chk("rst_rnd", 32'(rnd_o[1]), 32'd0);
        chk("rst_vld", 32'(vld_o[1]), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            cyc();
            chk($sformatf("w3_ready_e%0d", e), 32'(rdy_o[1]), (e == 4) ? 32'd1 : 32'd0);
            chk($sformatf("w0_ready_e%0d", e), 32'(rdy_o[0]), 32'd1);
        end

        // Three ch0 draws on the WARMUP=0 instance
        next = 2'b01;
        cyc();
`ifdef LFSR_LEAP_EN
        chk("leap_draw0", 32'(rnd_o[0][7:0]), 32'h0000_00D8);
`else
        chk("draw0", 32'(rnd_o[0][7:0]), 32'h0000_00CB);
`endif
        chk("draw0_vld", 32'(vld_o[0]), 32'd1);
        cyc();
`ifndef LFSR_LEAP_EN
        chk("draw1", 32'(rnd_o[0][7:0]), 32'h0000_00D1);
`endif
        cyc();
`ifndef LFSR_LEAP_EN
        chk("draw2", 32'(rnd_o[0][7:0]), 32'h0000_00DC);
`endif
        chk("ch1_idle", 32'(rnd_o[0][15:8]), 32'd0);
        chk("draw2_vld", 32'(vld_o[0]), 32'd1);

        next = 2'b10;
        cyc();
`ifndef LFSR_LEAP_EN
        chk("ch1_draw", 32'(rnd_o[0][15:8]), 32'h0000_007F);
`endif
        chk("ch1_vld", 32'(vld_o[0]), 32'd2);

        // Zero seed reseed with next asserted in the load cycle
        seed = 16'h0000;
        load = 1'b1;
        next = 2'b11;
        cyc();
        chk("load_vld", 32'(vld_o[0]), 32'd0);
        chk("load_ready", 32'(rdy_o[0]), 32'd0);
`ifndef LFSR_LEAP_EN
        chk("load_rnd_kept", 32'(rnd_o[0]), 32'h0000_7FDC);
`endif
        load = 1'b0;
        next = 2'b00;
        cyc();
        chk("reload_ready", 32'(rdy_o[0]), 32'd1);
        next = 2'b11;
        cyc();
`ifdef LFSR_LEAP_EN
        chk("zseed_ch0_leap", 32'(rnd_o[0][7:0]), 32'h0000_00D8);
`else
        chk("zseed_ch0", 32'(rnd_o[0][7:0]), 32'h0000_00CB);
        chk("zseed_ch1", 32'(rnd_o[0][15:8]), 32'h0000_00B4);
`endif

        // Reset mid-warm-up with next held high
        seed = 16'h1234;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            cyc();
            chk($sformatf("mid_ready_e%0d", e), 32'(rdy_o[1]), (e >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("mid_vld_e%0d", e), 32'(vld_o[1]), (e == 5) ? 32'd3 : 32'd0);
        end

        // Load during READY with next held high
        seed = 16'hACE1;
        load = 1'b1;
        cyc();
        chk("rdy_load_ready", 32'(rdy_o[1]), 32'd0);
        chk("rdy_load_vld", 32'(vld_o[1]), 32'd0);
        load = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            cyc();
            chk($sformatf("rl_vld_e%0d", e), 32'(vld_o[1]), 32'd0);
        end
        chk("rl_ready", 32'(rdy_o[1]), 32'd1);

        // Mixed request patterns, checked by the model
        for (int p = 0; p < 16; p++) begin
            next = pat[p];
            cyc();
        end
        next = 2'b00;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_bank.md
# lfsr_bank

Parametrised bank of independent Galois LFSR pseudo-random generators for the PDES event engine: NUM_CH channels, each supplying an OUT_W-bit random draw on request. Seeded from one WIDTH-bit seed with per-channel diversification. Includes a warm-up phase and runtime reseed. Replaces the single fixed 16-bit/8-bit generator where several event processors need uncorrelated random streams per cycle.

## Interface
- WIDTH, 16: LFSR state width (≥ OUT_W, ≥ 4).
- OUT_W, 8: draw width; draw = top OUT_W bits of channel state.
- NUM_CH, 4: number of independent channels (1..64).
- TAPS, 16'hB400: Galois feedback mask, WIDTH bits (default is x^16+x^14+x^13+x^11+1).
- WARMUP, 16: advance cycles after reset/reseed before ready (0 allowed).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seed  in  WIDTH  base seed; sampled on any cycle with rst=1 or load=1.
- load  in  1  reseed pulse.
- next  in  NUM_CH  per-channel draw request.
- ready  out  1  bank in READY state; draws accepted.
- rnd  out  NUM_CH*OUT_W  channel i draw at [i*OUT_W +: OUT_W].
- rnd_vld  out  NUM_CH  one-cycle pulse per channel when its rnd slice is updated.

## Operation
- Step function (one step): lsb = s[0]; s = s >> 1; if lsb, s ^= TAPS.
- Channel seed: seed_i = seed ^ i (i zero-extended to WIDTH). If seed_i == 0, all-ones is loaded instead (lockup guard).
- FSM states: WARM, READY.
- rst=1: every channel state <= seed_i; counter <= WARMUP; FSM <= WARM; ready, rnd, rnd_vld <= 0.
- WARM: every channel advances one draw-step per cycle; counter decrements. When counter is 0 at a clock edge, FSM moves to READY. WARMUP=0 gives READY on the first edge after rst/load. next is ignored in WARM.
- READY: next[i]=1 advances channel i by one draw-step. On the same edge rnd slice i <= top OUT_W bits of the new state and rnd_vld[i] <= 1. Channels without next hold both state and rnd slice.
- load=1 in any state: identical to reset except rnd keeps its value; rnd_vld <= 0. Any next in that cycle is dropped.
- load during WARM restarts the warm-up count.
- rst has priority over load.

## Timing
- Draw latency: 1 cycle. next[i] sampled at edge k gives rnd/rnd_vld valid after edge k. Back-to-back next gives one new draw every cycle per channel.
- ready is registered; it rises WARMUP+1 edges after the last rst/load edge.
- All channels are fully parallel; no arbitration and no stall.
- rnd_vld is never high for a cycle in which ready was low at the sampling edge.

## Configuration
- LFSR_LEAP_EN defined: one draw-step = OUT_W unrolled single steps in one cycle (leap-forward). Consecutive draws share no state bits. Warm-up also advances OUT_W steps per cycle.
- Not defined: one draw-step = one single step. Consecutive draws are shifted copies (lower cost).

## Test plan
- Reset/ready: WARMUP=3, hold rst 2 cycles then release. Required: ready=0, rnd=0, rnd_vld=0 during reset; ready rises on the 4th edge after release.
- Single-step sequence (macro off): WIDTH=16, OUT_W=8, NUM_CH=2, WARMUP=0, seed=16'hFFFF, next=2'b01 for 3 cycles. Required: ch0 rnd = 8'hCB, 8'hD1, 8'hDC; rnd_vld[0] high 3 cycles; rnd_vld[1]=0; ch1 slice stays 0.
- Channel diversity: same configuration, one draw on ch1 only. Required: ch1 rnd = 8'h7F (seed 16'hFFFE).
- Leap (macro on): same configuration, one ch0 draw. Required: rnd = 8'hD8 (state 16'hD827).
- Zero-seed guard and reseed: seed=16'h0000, pulse load while next=1. Required: the next is dropped; ch0 loads 16'hFFFF; ch1 loads 16'h0001; first ch0 draw (macro off) = 8'hCB.
- Reset mid-warm-up and load during READY with next held high. Required: no rnd_vld pulse until ready reasserts; ready drops on the edge after load.
